// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, product vend strobe and hopper change payout sequencer
module vend_sequencer #(
  parameter int PRICE_A    = 25,
  parameter int PRICE_B    = 35,
  parameter int MAX_CREDIT = 95
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       co5,
  input  logic       co10,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  input  logic       hop_ack,
  output logic [6:0] credit,
  output logic       vend_a,
  output logic       vend_b,
  output logic       hop5,
  output logic       hop10,
  output logic       reject,
  output logic       insuff,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, VEND, CHG, CHG_WAIT, CHG_GAP} state_t;
  localparam logic [6:0] PA = 7'(PRICE_A);
  localparam logic [6:0] PB = 7'(PRICE_B);
  localparam logic [7:0] MAXC = 8'(MAX_CREDIT);
  state_t state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic prod_b_q, prod_b_d;
  logic c10_q, c10_d;
  logic reject_q, reject_d;
  logic insuff_q, insuff_d;
  logic [4:0] hist_q;
  logic e5, e10, ka, kb, kc, acc;
  logic [7:0] coin_sum;
  logic [6:0] p_sel, p_vend;
  assign e5 = hist_q[4] & ~co5;
  assign e10 = hist_q[3] & ~co10;
  assign ka = ~hist_q[2] & sel_a;
  assign kb = ~hist_q[1] & sel_b;
  assign kc = ~hist_q[0] & cancel;
  assign coin_sum = {1'b0, credit_q} + (e5 ? 8'd5 : 8'd0) + (e10 ? 8'd10 : 8'd0);
  assign p_sel = ka ? PA : PB;
  assign p_vend = prod_b_q ? PB : PA;
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    prod_b_d = prod_b_q;
    c10_d = c10_q;
    insuff_d = 1'b0;
    acc = 1'b0;
    reject_d = e5 | e10;
    case (state_q)
      IDLE: begin
        if (ka | kb) begin
          if (credit_q >= p_sel) begin
            state_d = VEND;
            prod_b_d = ~ka;
            acc = 1'b1;
          end else insuff_d = 1'b1;
        end else if (kc && credit_q != 7'd0) begin
          state_d = CHG;
          acc = 1'b1;
        end
        // coins arriving with an accepted key are refused outright, never partially banked
        reject_d = (e5 | e10) & (acc | coin_sum > MAXC);
        credit_d = ((e5 | e10) & ~reject_d) ? coin_sum[6:0] : credit_q;
      end
      VEND: begin
        credit_d = credit_q - p_vend;
        state_d = CHG;
      end
      CHG: begin
        state_d = credit_q == 7'd0 ? IDLE : CHG_WAIT;
        c10_d = credit_q >= 7'd10;
      end
      CHG_WAIT: begin
        if (hop_ack) begin
          credit_d = credit_q - (c10_q ? 7'd10 : 7'd5);
          state_d = CHG_GAP;
        end
      end
      CHG_GAP: state_d = CHG;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= IDLE;
      credit_q <= '0;
      prod_b_q <= 1'b0;
      c10_q <= 1'b0;
      reject_q <= 1'b0;
      insuff_q <= 1'b0;
      hist_q <= '0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      prod_b_q <= prod_b_d;
      c10_q <= c10_d;
      reject_q <= reject_d;
      insuff_q <= insuff_d;
      hist_q <= {co5, co10, sel_a, sel_b, cancel};
    end
  end
  // request rises in CHG so it follows the vend strobe by one cycle, then is held through CHG_WAIT
  assign hop10 = (state_q == CHG && credit_q >= 7'd10) || (state_q == CHG_WAIT && c10_q);
  assign hop5 = (state_q == CHG && credit_q != 7'd0 && credit_q < 7'd10) || (state_q == CHG_WAIT && !c10_q);
  assign vend_a = state_q == VEND && !prod_b_q;
  assign vend_b = state_q == VEND && prod_b_q;
  assign busy = state_q != IDLE;
  assign credit = credit_q;
  assign reject = reject_q;
  assign insuff = insuff_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: table-driven and directed checks of the vending sequencer
module tb_vend_sequencer;
  typedef struct {
    logic [6:0] in;
    logic [6:0] cr;
    logic [6:0] fl;
  } vec_t;
  logic ck = 1'b0;
  logic reset = 1'b1, co5 = 1'b0, co10 = 1'b0, sel_a = 1'b0, sel_b = 1'b0, cancel = 1'b0, hop_ack = 1'b0;
  logic [6:0] credit;
  logic vend_a, vend_b, hop5, hop10, reject, insuff, busy;
  int errors = 0;
  int checks = 0;
  vec_t tv[19];
  always #5 ck = ~ck;
  vend_sequencer dut (
    .ck(ck), .reset(reset), .co5(co5), .co10(co10), .sel_a(sel_a), .sel_b(sel_b),
    .cancel(cancel), .hop_ack(hop_ack), .credit(credit), .vend_a(vend_a), .vend_b(vend_b),
    .hop5(hop5), .hop10(hop10), .reject(reject), .insuff(insuff), .busy(busy)
  );
  function automatic logic [13:0] obs();
    return {credit, vend_a, vend_b, hop5, hop10, reject, insuff, busy};
  endfunction
  task automatic tick();
    @(posedge ck);
    #1;
  endtask
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d flags=%b expected credit=%0d flags=%b", name, act[13:7], act[6:0], exp[13:7], exp[6:0]);
    end
  endtask
  task automatic coin(input logic c5, input logic c10);
    co5 = c5;
    co10 = c10;
    tick();
    co5 = 1'b0;
    co10 = 1'b0;
    tick();
  endtask
  function automatic logic [6:0] hf(input logic c10);
    return c10 ? 7'b0001001 : 7'b0010001;
  endfunction
  initial begin
    logic [6:0] cb[3];
    logic [6:0] ca[3];
    logic c10s[4];
    logic [13:0] nxt;
    // in = {reset,co5,co10,sel_a,sel_b,cancel,hop_ack}; fl = {vend_a,vend_b,hop5,hop10,reject,insuff,busy}
    tv = '{
      '{7'b1000000, 7'd0,  7'b0000000},
      '{7'b0010000, 7'd0,  7'b0000000},
      '{7'b0000000, 7'd10, 7'b0000000},
      '{7'b0010000, 7'd10, 7'b0000000},
      '{7'b0000000, 7'd20, 7'b0000000},
      '{7'b0010000, 7'd20, 7'b0000000},
      '{7'b0000000, 7'd30, 7'b0000000},
      '{7'b0001000, 7'd30, 7'b1000001},
      '{7'b0000000, 7'd5,  7'b0010001},
      '{7'b0000000, 7'd5,  7'b0010001},
      '{7'b0000001, 7'd0,  7'b0000001},
      '{7'b0000000, 7'd0,  7'b0000001},
      '{7'b0000000, 7'd0,  7'b0000000},
      '{7'b0010000, 7'd0,  7'b0000000},
      '{7'b0000000, 7'd10, 7'b0000000},
      '{7'b0010000, 7'd10, 7'b0000000},
      '{7'b0000000, 7'd20, 7'b0000000},
      '{7'b0000100, 7'd20, 7'b0000010},
      '{7'b0000000, 7'd20, 7'b0000000}
    };
    for (int i = 0; i < 19; i++) begin
      {reset, co5, co10, sel_a, sel_b, cancel, hop_ack} = tv[i].in;
      tick();
      chk($sformatf("row%0d", i), obs(), {tv[i].cr, tv[i].fl});
    end
    reset = 1'b0;
    repeat (7) coin(1'b0, 1'b1);
    chk("fill90", obs(), {7'd90, 7'b0000000});
    coin(1'b0, 1'b1);
    chk("over_reject", obs(), {7'd90, 7'b0000100});
    tick();
    chk("reject_one_cycle", obs(), {7'd90, 7'b0000000});
    coin(1'b1, 1'b0);
    chk("fill95", obs(), {7'd95, 7'b0000000});
    coin(1'b1, 1'b1);
    chk("both_reject", obs(), {7'd95, 7'b0000100});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    coin(1'b0, 1'b1);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    chk("fill25", obs(), {7'd25, 7'b0000000});
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_hop", obs(), {7'd25, 7'b0001001});
    cb = '{7'd25, 7'd15, 7'd5};
    ca = '{7'd15, 7'd5, 7'd0};
    c10s = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      repeat (3) begin
        tick();
        chk($sformatf("hold%0d", i), obs(), {cb[i], hf(c10s[i])});
      end
      hop_ack = 1'b1;
      tick();
      hop_ack = 1'b0;
      chk($sformatf("gap%0d", i), obs(), {ca[i], 7'b0000001});
      tick();
      nxt = ca[i] == 7'd0 ? {7'd0, 7'b0000001} : {ca[i], hf(c10s[i+1])};
      chk($sformatf("next%0d", i), obs(), nxt);
    end
    tick();
    chk("payout_idle", obs(), {7'd0, 7'b0000000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    coin(1'b0, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    co5 = 1'b1;
    tick();
    co5 = 1'b0;
    tick();
    chk("coin_in_wait", obs(), {7'd10, 7'b0001101});
    hop_ack = 1'b1;
    tick();
    hop_ack = 1'b0;
    tick();
    tick();
    chk("wait_done_idle", obs(), {7'd0, 7'b0000000});
    repeat (4) coin(1'b0, 1'b1);
    chk("fill40", obs(), {7'd40, 7'b0000000});
    sel_a = 1'b1;
    sel_b = 1'b1;
    tick();
    chk("both_sel_vend_a", obs(), {7'd40, 7'b1000001});
    sel_a = 1'b0;
    sel_b = 1'b0;
    tick();
    chk("after_vend", obs(), {7'd15, 7'b0001001});
    tick();
    chk("hop10_held", obs(), {7'd15, 7'b0001001});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_payout", obs(), {7'd0, 7'b0000000});
    hop_ack = 1'b1;
    tick();
    hop_ack = 1'b0;
    chk("late_ack", obs(), {7'd0, 7'b0000000});
    tick();
    chk("still_idle", obs(), {7'd0, 7'b0000000});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Top-level sequencer for the coin vending datapath. It debounces coin-release events into a credit register and sequences product selection, a one-cycle vend strobe, and change payout. Change is paid through a coin hopper using a req/ack handshake, one coin at a time. It sits between the coin acceptor / keypad inputs and the dispenser / hopper actuators.

Parameters:
PRICE_A, 25, price of product A in credit units (multiple of 5, 5..MAX_CREDIT)
PRICE_B, 35, price of product B in credit units (multiple of 5, 5..MAX_CREDIT)
MAX_CREDIT, 95, maximum credit held; multiple of 5, <= 127

Ports:
ck  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
co5  input  1  5-unit coin present (level); coin counted on falling edge
co10  input  1  10-unit coin present (level); counted on falling edge
sel_a  input  1  select product A (level); acted on at rising edge
sel_b  input  1  select product B (level); acted on at rising edge
cancel  input  1  refund request (level); acted on at rising edge
hop_ack  input  1  hopper accepted current coin request
credit  output  7  current credit, registered
vend_a  output  1  one-cycle dispense strobe, product A
vend_b  output  1  one-cycle dispense strobe, product B
hop5  output  1  request hopper to pay one 5-unit coin (held until ack)
hop10  output  1  request hopper to pay one 10-unit coin (held until ack)
reject  output  1  one-cycle pulse: coin event refused
insuff  output  1  one-cycle pulse: selection refused, credit < price
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high) forces state IDLE and all outputs to 0, including credit, strobes and hop5/hop10. Edge-detect history registers also clear. Any credit held is discarded. Reset mid-payout drops the hopper request at that edge.
- Edge detection: registered copies of co5, co10, sel_a, sel_b and cancel. A coin event is previous=1 and current=0. A key event is previous=0 and current=1. Events are evaluated in the same cycle the edge is seen.
- States: IDLE, VEND, CHG, CHG_WAIT, CHG_GAP.
- IDLE, per-cycle priority:
  1. Selection event: sel_a wins if both sel_a and sel_b fire.
     - If credit >= price: go to VEND, latch product.
     - Else: insuff=1 for one cycle, stay in IDLE.
  2. Cancel event with no selection event:
     - credit > 0: go to CHG.
     - credit == 0: ignored.
  3. Coins:
     - Coin value = 5 (co5 event) + 10 (co10 event); both in one cycle gives 15.
     - If an accepted selection or an accepted cancel occurs in the same cycle, the coins are refused: reject=1.
     - Else if credit + value <= MAX_CREDIT: credit += value on next edge.
     - Else: reject=1, credit unchanged (all-or-nothing).
- VEND, exactly one cycle:
  - vend_a or vend_b = 1 on the registered output.
  - credit <= credit - price.
  - Next state CHG.
- CHG:
  - credit == 0: go to IDLE.
  - credit >= 10: assert hop10, go to CHG_WAIT.
  - Otherwise: assert hop5, go to CHG_WAIT.
- CHG_WAIT:
  - Hold the request until hop_ack is sampled high.
  - On that edge: drop the request, credit -= coin value, go to CHG_GAP.
  - No timeout.
- CHG_GAP: one idle cycle with no request, then CHG. Consecutive requests are therefore separated by at least one low cycle.
- Any coin event outside IDLE: reject=1, credit unchanged. Key events outside IDLE are ignored and are not queued.
- Invariant: credit is always a multiple of 5, never exceeds MAX_CREDIT, and never underflows.
- Latency:
  - Coin release to credit update: 1 cycle.
  - Selection edge to vend strobe: 1 cycle; vend strobe to first hopper request: 1 cycle.

Test Plan:
1. co10 pulsed 3x, then sel_a (PRICE_A=25): credit reads 10/20/30; vend_a high one cycle; credit 5; hop5 asserts; ack -> credit 0, busy falls, IDLE.
2. Credit 20, sel_b (35): insuff high one cycle; no vend; credit stays 20; busy stays 0.
3. Credit 90, co10 released: reject pulse, credit 90. Then co5: credit 95. Then co5 and co10 released same cycle: reject, credit 95.
4. Credit 25, cancel: hop10, hop10, hop5 in that order. Each is held through a 3-cycle ack delay. Credit goes 15, 5, 0, with a gap cycle between requests.
5. co5 released during CHG_WAIT: reject pulse, credit unchanged. sel_a and sel_b rising together in IDLE with credit 40: vend_a only, credit 15.
6. reset asserted while hop10 is held: next edge hop10=0, credit=0, state IDLE; hop_ack afterward has no effect.
